packet_filter_ctrl: RTL and testbench
=====================================

// Module: packet_filter_ctrl
// PURPOSE
//  Sequencer between the packet_filter register map and the BPF filter core. Assembles 64-bit
//  instructions from inst_low/inst_high register writes into the core's instruction memory,
//  runs/halts the core from Control.start with a safe drain, maintains Status.num_packets_dropped.
// PARAMETERS
//  CODE_ADDR_WIDTH  10  instruction memory address width (depth 2**CODE_ADDR_WIDTH)
//  DROP_CNT_WIDTH   16  width of dropped-packet counter
// PORTS
//  axi_aclk                    in   1    clock
//  axi_aresetn                 in   1    asynchronous active-low reset
//  control_start               in   1    Control.start field (level)
//  inst_low_value              in   32   inst_low register value
//  inst_low_strobe             in   1    1-cycle pulse on inst_low write
//  inst_high_value             in   32   inst_high register value
//  inst_high_strobe            in   1    1-cycle pulse on inst_high write
//  inst_wr_en                  out  1    instruction memory write enable
//  inst_wr_addr                out  CODE_ADDR_WIDTH    instruction memory write address
//  inst_wr_data                out  64   {high,low} instruction word
//  code_len                    out  CODE_ADDR_WIDTH+1  number of instructions loaded
//  filter_run                  out  1    core enable; 1 only in RUNNING
//  filter_idle                 in   1    core has no packet in flight
//  pkt_drop                    in   1    1-cycle pulse per dropped packet
//  status_num_packets_dropped  out  DROP_CNT_WIDTH     Status field
//  load_error                  out  1    sticky load-protocol error
// BEHAVIOUR
//  Reset: all outputs 0; state HALTED; low_valid=0; reload_pending=0; counters 0.
//  FSM: HALTED -> RUNNING when control_start=1 and code_len!=0.
//       RUNNING -> DRAINING when control_start=0 (filter_run drops same cycle as transition).
//       DRAINING -> HALTED when filter_idle=1; sets reload_pending. start=1 in DRAINING ignored
//       until HALTED; then re-enters RUNNING next cycle if still 1 (code retained).
//  Loading (HALTED only): inst_low_strobe latches low half, low_valid=1.
//   inst_high_strobe with low_valid: next cycle inst_wr_en=1 for exactly 1 cycle,
//   inst_wr_addr=code_len (0 if reload_pending), data={inst_high_value,low}; code_len
//   increments (set to 1 if reload_pending); low_valid and reload_pending cleared.
//   Both strobes same cycle: write uses current inst_low_value directly.
//  Errors (load_error set, no memory write, state unchanged): inst_high_strobe without
//   low_valid; any strobe outside HALTED; inst_high write with code_len==2**CODE_ADDR_WIDTH
//   (full; no wrap). load_error cleared on HALTED->RUNNING transition.
//  Drop counter: cleared on HALTED->RUNNING; +1 per pkt_drop in any state; saturates at
//   all-ones. pkt_drop on clearing cycle -> counter=1.
//  Reset asserted mid-operation: immediate return to reset values; memory contents undefined
//   to software (code_len=0 forces reload before run).
// TESTING
//  1 Reset, write low=0x11,high=0x22 x3 (varying) -> 3 wr_en pulses, addr 0,1,2, code_len=3,
//    each pulse 1 cycle after high strobe with data {high,low}.
//  2 start=1 with code_len=0 -> stays HALTED, filter_run=0; after one load, start=1 ->
//    filter_run=1 next cycle, drop counter=0.
//  3 RUNNING, 5 pkt_drop pulses -> count=5; preload count to 0xFFFE, 3 drops -> 0xFFFF.
//  4 start=0 with filter_idle=0 for 10 cycles -> filter_run=0, DRAINING held; idle=1 ->
//    HALTED; new load writes addr 0, code_len=1.
//  5 high strobe without prior low, strobe while RUNNING, write when full (CODE_ADDR_WIDTH=2,
//    5th write) -> no wr_en, load_error=1; next start clears it.
//  6 Assert axi_aresetn low mid-write and while RUNNING -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/packet_filter_ctrl.sv
// packet_filter_ctrl: sequencer between the packet_filter register map and the BPF core.
// Builds 64-bit instructions from inst_low/inst_high writes, gates the core with a safe
// drain on stop, and keeps the dropped-packet status counter.
module packet_filter_ctrl #(
    parameter int CODE_ADDR_WIDTH = 10,
    parameter int DROP_CNT_WIDTH  = 16
) (
    input  logic                       axi_aclk,
    input  logic                       axi_aresetn,
    input  logic                       control_start,
    input  logic [31:0]                inst_low_value,
    input  logic                       inst_low_strobe,
    input  logic [31:0]                inst_high_value,
    input  logic                       inst_high_strobe,
    output logic                       inst_wr_en,
    output logic [CODE_ADDR_WIDTH-1:0] inst_wr_addr,
    output logic [63:0]                inst_wr_data,
    output logic [CODE_ADDR_WIDTH:0]   code_len,
    output logic                       filter_run,
    input  logic                       filter_idle,
    input  logic                       pkt_drop,
    output logic [DROP_CNT_WIDTH-1:0]  status_num_packets_dropped,
    output logic                       load_error
);

    typedef enum logic [1:0] {
        HALTED   = 2'd0,
        RUNNING  = 2'd1,
        DRAINING = 2'd2
    } state_e;

    // A full memory holds exactly 2**CODE_ADDR_WIDTH instructions; loads never wrap.
    localparam logic [CODE_ADDR_WIDTH:0]  FULL_LEN = {1'b1, {CODE_ADDR_WIDTH{1'b0}}};
    localparam logic [CODE_ADDR_WIDTH:0]  LEN_ONE  = 1;
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_ONE = 1;
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX = '1;

    state_e                      state_q, state_d;
    logic                        run_q, run_d;
    logic                        low_valid_q, low_valid_d;
    logic [31:0]                 low_q, low_d;
    logic                        reload_q, reload_d;
    logic [CODE_ADDR_WIDTH:0]    code_len_q, code_len_d;
    logic                        wr_en_q, wr_en_d;
    logic [CODE_ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [63:0]                 wr_data_q, wr_data_d;
    logic [DROP_CNT_WIDTH-1:0]   drop_q, drop_d;
    logic                        err_q, err_d;

    logic                        halted;
    logic                        have_low;
    logic [31:0]                 low_word;
    logic                        full;
    logic                        do_write;
    logic                        bad_load;
    logic                        go_run;

    // Decode the load request and compute every next-state value for this cycle.
    always_comb begin
        halted   = (state_q == HALTED);
        have_low = inst_low_strobe | low_valid_q;
        low_word = inst_low_strobe ? inst_low_value : low_q;
        full     = !reload_q && (code_len_q == FULL_LEN);
        do_write = halted && inst_high_strobe && have_low && !full;
        bad_load = (!halted && (inst_low_strobe || inst_high_strobe)) ||
                   (halted && inst_high_strobe && (!have_low || full));
        go_run   = halted && control_start && (code_len_q != '0);

        state_d = state_q;
        case (state_q)
            HALTED:   if (go_run)         state_d = RUNNING;
            RUNNING:  if (!control_start) state_d = DRAINING;
            DRAINING: if (filter_idle)    state_d = HALTED;
            default:                      state_d = HALTED;
        endcase
        run_d = (state_d == RUNNING);

        reload_d = reload_q;
        if (do_write) begin
            reload_d = 1'b0;
        end else if (state_q == DRAINING && filter_idle) begin
            reload_d = 1'b1;
        end

        low_valid_d = low_valid_q;
        low_d       = low_q;
        if (do_write) begin
            low_valid_d = 1'b0;
        end else if (halted && inst_low_strobe && !inst_high_strobe) begin
            low_valid_d = 1'b1;
            low_d       = inst_low_value;
        end

        code_len_d = code_len_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = do_write;
        if (do_write) begin
            code_len_d = reload_q ? LEN_ONE : (code_len_q + LEN_ONE);
            wr_addr_d  = reload_q ? '0 : code_len_q[CODE_ADDR_WIDTH-1:0];
            wr_data_d  = {inst_high_value, low_word};
        end

        err_d = err_q;
        if (bad_load) begin
            err_d = 1'b1;
        end else if (go_run) begin
            err_d = 1'b0;
        end

        drop_d = drop_q;
        if (go_run) begin
            drop_d = pkt_drop ? DROP_ONE : '0;
        end else if (pkt_drop && drop_q != DROP_MAX) begin
            drop_d = drop_q + DROP_ONE;
        end
    end

    // Register FSM state, load bookkeeping and all outputs; reset returns everything to zero.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q     <= HALTED;
            run_q       <= 1'b0;
            low_valid_q <= 1'b0;
            low_q       <= '0;
            reload_q    <= 1'b0;
            code_len_q  <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            drop_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            low_valid_q <= low_valid_d;
            low_q       <= low_d;
            reload_q    <= reload_d;
            code_len_q  <= code_len_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            drop_q      <= drop_d;
            err_q       <= err_d;
        end
    end

    assign inst_wr_en                 = wr_en_q;
    assign inst_wr_addr               = wr_addr_q;
    assign inst_wr_data               = wr_data_q;
    assign code_len                   = code_len_q;
    assign filter_run                 = run_q;
    assign status_num_packets_dropped = drop_q;
    assign load_error                 = err_q;

endmodule

// File: tb/tb_packet_filter_ctrl.sv
// tb_packet_filter_ctrl: directed and random stimulus against a program-list reference model,
// with instruction writes checked by a scoreboard monitor.
module tb_packet_filter_ctrl;

    localparam int CAW      = 2;
    localparam int DCW      = 8;
    localparam int DEPTH    = 1 << CAW;
    localparam int DROP_MAX = (1 << DCW) - 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [31:0]    lowV, highV;
    logic           lowS, highS;
    logic           idle, drop;
    logic           wrEn;
    logic [CAW-1:0] wrAddr;
    logic [63:0]    wrData;
    logic [CAW:0]   codeLen;
    logic           run;
    logic [DCW-1:0] drops;
    logic           err;

    // Free-running clock.
    always #5 clk = ~clk;

    packet_filter_ctrl #(.CODE_ADDR_WIDTH(CAW), .DROP_CNT_WIDTH(DCW)) dut (
        .axi_aclk                  (clk),
        .axi_aresetn               (rst_n),
        .control_start             (start),
        .inst_low_value            (lowV),
        .inst_low_strobe           (lowS),
        .inst_high_value           (highV),
        .inst_high_strobe          (highS),
        .inst_wr_en                (wrEn),
        .inst_wr_addr              (wrAddr),
        .inst_wr_data              (wrData),
        .code_len                  (codeLen),
        .filter_run                (run),
        .filter_idle               (idle),
        .pkt_drop                  (drop),
        .status_num_packets_dropped(drops),
        .load_error                (err)
    );

    typedef struct {
        int          addr;
        logic [63:0] data;
        int          len;
    } wr_t;

    wr_t expQ[$];
    int  tests = 0;
    int  fails = 0;

    // Reference model: mode 0 halted, 1 running, 2 draining; loaded program kept as a list.
    int          mMode;
    logic [63:0] mProg[$];
    bit          mReload, mLowValid, mErr;
    logic [31:0] mLow;
    int          mDrops;
    bit          curStart;
    bit          curIdle;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mMode = 0;
        mProg.delete();
        mReload = 0;
        mLowValid = 0;
        mLow = '0;
        mDrops = 0;
        mErr = 0;
        expQ.delete();
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic modelStep();
        int          oldLen;
        int          prevMode;
        bit          newErr;
        bit          toRun;
        wr_t         w;
        logic [31:0] lw;
        oldLen   = mProg.size();
        prevMode = mMode;
        newErr   = 0;
        toRun    = 0;
        if ((lowS || highS) && prevMode != 0) begin
            newErr = 1;
        end else if (prevMode == 0) begin
            if (highS) begin
                if (!(lowS || mLowValid)) begin
                    newErr = 1;
                end else if (!mReload && oldLen == DEPTH) begin
                    newErr = 1;
                end else begin
                    lw = lowS ? lowV : mLow;
                    if (mReload) mProg.delete();
                    w.addr = mProg.size();
                    w.data = {highV, lw};
                    mProg.push_back(w.data);
                    w.len = mProg.size();
                    expQ.push_back(w);
                    mLowValid = 0;
                    mReload = 0;
                end
            end else if (lowS) begin
                mLow = lowV;
                mLowValid = 1;
            end
        end
        if (prevMode == 0 && start && oldLen != 0) begin
            mMode = 1;
            toRun = 1;
        end else if (prevMode == 1 && !start) begin
            mMode = 2;
        end else if (prevMode == 2 && idle) begin
            mMode = 0;
            mReload = 1;
        end
        if (toRun) mDrops = drop ? 1 : 0;
        else if (drop && mDrops < DROP_MAX) mDrops++;
        if (newErr) mErr = 1;
        else if (toRun) mErr = 0;
    endtask

    // Scoreboard monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        wr_t w;
        if (rst_n && wrEn) begin
            if (expQ.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL wr_unexpected: got addr %0d data %0h, required no write", wrAddr, wrData);
            end else begin
                w = expQ.pop_front();
                checkOutput("wr_addr", 64'(wrAddr), 64'(w.addr));
                checkOutput("wr_data", wrData, w.data);
                checkOutput("wr_code_len", 64'(codeLen), 64'(w.len));
            end
        end
    end

    // One clock of stimulus: drive, model, check state after the edge, confirm writes consumed.
    task automatic applyStimulus(input bit st, input bit ls, input logic [31:0] lv,
                                 input bit hs, input logic [31:0] hv, input bit id, input bit dr);
        start = st;
        lowS  = ls;
        lowV  = lv;
        highS = hs;
        highV = hv;
        idle  = id;
        drop  = dr;
        modelStep();
        @(posedge clk);
        #1;
        checkOutput("filter_run", 64'(run), 64'(mMode == 1));
        checkOutput("code_len", 64'(codeLen), 64'(mProg.size()));
        checkOutput("drop_cnt", 64'(drops), 64'(mDrops));
        checkOutput("load_error", 64'(err), 64'(mErr));
        @(negedge clk);
        #1;
        checkOutput("wr_missing", 64'(expQ.size()), 64'd0);
    endtask

    task automatic cyc(input bit dr);
        applyStimulus(curStart, 0, '0, 0, '0, curIdle, dr);
    endtask

    task automatic loadLow(input logic [31:0] v);
        applyStimulus(curStart, 1, v, 0, '0, curIdle, 0);
    endtask

    task automatic loadHigh(input logic [31:0] v);
        applyStimulus(curStart, 0, '0, 1, v, curIdle, 0);
    endtask

    task automatic doReset(input string tag);
        rst_n = 1'b0;
        curStart = 0;
        curIdle = 1;
        start = 0; lowS = 0; highS = 0; lowV = '0; highV = '0; idle = 1; drop = 0;
        #2;
        checkOutput({tag, "_wr_en"}, 64'(wrEn), 64'd0);
        checkOutput({tag, "_wr_addr"}, 64'(wrAddr), 64'd0);
        checkOutput({tag, "_wr_data"}, wrData, 64'd0);
        checkOutput({tag, "_code_len"}, 64'(codeLen), 64'd0);
        checkOutput({tag, "_run"}, 64'(run), 64'd0);
        checkOutput({tag, "_drops"}, 64'(drops), 64'd0);
        checkOutput({tag, "_err"}, 64'(err), 64'd0);
        modelReset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] timeout");
    end

    // Main sequence.
    initial begin
        rst_n = 1'b1;
        start = 0; lowS = 0; highS = 0; lowV = '0; highV = '0; idle = 1; drop = 0;
        curStart = 0;
        curIdle = 1;
        #1;
        doReset("reset");

        // Three instruction loads with varying values.
        for (int i = 0; i < 3; i++) begin
            loadLow(32'h11 + i);
            loadHigh(32'h22 + 32'(i * 16));
        end
        checkOutput("t1_code_len", 64'(codeLen), 64'd3);

        // Start refused while empty, accepted after one load.
        doReset("t2_reset");
        curStart = 1;
        cyc(0);
        checkOutput("t2_empty_run", 64'(run), 64'd0);
        curStart = 0;
        loadLow(32'hA5A5_0001);
        loadHigh(32'h5A5A_0002);
        curStart = 1;
        cyc(0);
        checkOutput("t2_run", 64'(run), 64'd1);
        checkOutput("t2_drops", 64'(drops), 64'd0);

        // Drop counting and saturation.
        for (int i = 0; i < 5; i++) cyc(1);
        checkOutput("t3_drops5", 64'(drops), 64'd5);
        for (int i = 0; i < DROP_MAX + 5; i++) cyc(1);
        checkOutput("t3_drops_sat", 64'(drops), 64'(DROP_MAX));

        // Drain held while core busy, then reload from address 0.
        curStart = 0;
        curIdle = 0;
        for (int i = 0; i < 10; i++) cyc(0);
        checkOutput("t4_drain_run", 64'(run), 64'd0);
        curIdle = 1;
        cyc(0);
        loadLow(32'hCAFE_0000);
        loadHigh(32'hBEEF_0000);
        checkOutput("t4_reload_len", 64'(codeLen), 64'd1);

        // Load protocol errors.
        doReset("t5_reset");
        loadHigh(32'h1234_5678);
        checkOutput("t5_err_nolow", 64'(err), 64'd1);
        for (int i = 0; i < DEPTH + 1; i++) begin
            loadLow(32'h100 + i);
            loadHigh(32'h200 + i);
        end
        checkOutput("t5_full_len", 64'(codeLen), 64'(DEPTH));
        checkOutput("t5_err_full", 64'(err), 64'd1);
        curStart = 1;
        cyc(0);
        checkOutput("t5_err_cleared", 64'(err), 64'd0);
        loadLow(32'hDEAD_0000);
        checkOutput("t5_err_running", 64'(err), 64'd1);

        // Asynchronous reset during a write pulse and while running.
        doReset("t6_pre");
        lowS = 1; lowV = 32'h7777_0000; highS = 1; highV = 32'h8888_0000;
        start = 0; idle = 1; drop = 0;
        modelStep();
        @(posedge clk);
        #1;
        checkOutput("t6_wr_en_before", 64'(wrEn), 64'd1);
        doReset("t6_midwrite");
        loadLow(32'h1);
        loadHigh(32'h2);
        curStart = 1;
        cyc(1);
        cyc(1);
        checkOutput("t6_running", 64'(run), 64'd1);
        doReset("t6_running");

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) curStart = !curStart;
            applyStimulus(curStart,
                          $urandom_range(0, 3) == 0, $urandom,
                          $urandom_range(0, 3) == 0, $urandom,
                          $urandom_range(0, 2) != 0,
                          $urandom_range(0, 2) == 0);
        end

        checkOutput("final_queue_empty", 64'(expQ.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
